uart_tx_arbiter: RTL and testbench

- Shares the single UART transmitter among NREQ byte-stream requesters using round-robin arbitration.
- Optional lock keeps multi-byte messages contiguous.
- Owns the UART load handshake: drives ld_tx_data, tx_data and tx_enable, and watches tx_empty.
- Sits between client logic and the uart instance in system; the UART runs on the slower baud clock, so tx_empty is synchronised into clk.

---
 rtl/uart_arb_pkg.sv | 11 +
 rtl/uart_tx_arbiter_sync2.sv | 27 ++
 rtl/uart_tx_arbiter.sv | 153 +++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_arb_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM state encoding
// and the default abort timeout in clk cycles.
package uart_arb_pkg;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LOAD = 2'd1;
    localparam logic [1:0] SEND = 2'd2;

    localparam int DEFAULT_TIMEOUT = 50000;

endpackage

// File: rtl/uart_tx_arbiter_sync2.sv
// Generic two-flop synchroniser with asynchronous active-low reset
// to a selectable reset value.
module sync2 #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta_reg;
    logic q_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta_reg <= RST_VAL;
            q_reg    <= RST_VAL;
        end else begin
            meta_reg <= d;
            q_reg    <= meta_reg;
        end
    end

    assign q = q_reg;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NREQ byte
// requesters, with per-requester lock for contiguous multi-byte messages.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = DEFAULT_TIMEOUT,
    parameter int PTR_W   = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   req,
    input  logic [8*NREQ-1:0] req_data,
    input  logic [NREQ-1:0]   lock,
    output logic [NREQ-1:0]   gnt,
    output logic              uart_ld_tx_data,
    output logic [7:0]        uart_tx_data,
    output logic              uart_tx_enable,
    input  logic              uart_tx_empty,
    output logic              busy,
    output logic              err_timeout
);

    localparam int CNT_W = $clog2(TIMEOUT) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [PTR_W-1:0] PTR_MAX  = PTR_W'(NREQ - 1);

    logic [1:0]       state_reg, state_next;
    logic [PTR_W-1:0] ptr_reg, ptr_next;
    logic [PTR_W-1:0] last_reg, last_next;
    logic [7:0]       data_reg, data_next;
    logic [NREQ-1:0]  gnt_reg, gnt_next;
    logic             ld_reg, ld_next;
    logic             err_reg, err_next;
    logic             en_reg;
    logic [CNT_W-1:0] cnt_reg, cnt_next;

    logic             empty_s;
    logic [PTR_W-1:0] winner;
    logic             found;
    logic             grant;
    logic             timeout_hit;
    logic [7:0]       req_bytes [NREQ];

    sync2 #(.RST_VAL(1'b1)) u_sync2 (
        .clk   (clk),
        .reset (reset),
        .d     (uart_tx_empty),
        .q     (empty_s)
    );

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_bytes
        assign req_bytes[gi] = req_data[8*gi +: 8];
    end

    // A locked previous grantee that is still requesting beats the rotation.
    always_comb begin
        int idx;
        idx    = 0;
        winner = ptr_reg;
        found  = 1'b0;
        if (lock[last_reg] && req[last_reg]) begin
            winner = last_reg;
            found  = 1'b1;
        end else begin
            for (int k = 0; k < NREQ; k++) begin
                idx = int'(ptr_reg) + k;
                if (idx >= NREQ) idx = idx - NREQ;
                if (!found && req[idx]) begin
                    found  = 1'b1;
                    winner = PTR_W'(idx);
                end
            end
        end
    end

    assign grant       = (state_reg == IDLE) && empty_s && found;
    assign timeout_hit = ((state_reg == LOAD) || (state_reg == SEND)) && (cnt_reg == CNT_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
            ptr_reg   <= '0;
            last_reg  <= '0;
            data_reg  <= '0;
            gnt_reg   <= '0;
            ld_reg    <= 1'b0;
            err_reg   <= 1'b0;
            en_reg    <= 1'b0;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            ptr_reg   <= ptr_next;
            last_reg  <= last_next;
            data_reg  <= data_next;
            gnt_reg   <= gnt_next;
            ld_reg    <= ld_next;
            err_reg   <= err_next;
            en_reg    <= 1'b1;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (grant) state_next = LOAD;
            LOAD: begin
                if (timeout_hit)   state_next = IDLE;
                else if (!empty_s) state_next = SEND;
            end
            SEND: begin
                if (timeout_hit)  state_next = IDLE;
                else if (empty_s) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Next values of the registered outputs and datapath.
    always_comb begin
        ptr_next  = ptr_reg;
        last_next = last_reg;
        data_next = data_reg;
        gnt_next  = '0;
        ld_next   = ld_reg;
        err_next  = 1'b0;
        cnt_next  = cnt_reg;
        if (grant) begin
            data_next = req_bytes[winner];
            gnt_next  = NREQ'(1) << winner;
            last_next = winner;
            ptr_next  = (winner == PTR_MAX) ? '0 : winner + 1'b1;
            ld_next   = 1'b1;
            cnt_next  = '0;
        end else if (timeout_hit) begin
            err_next = 1'b1;
            ld_next  = 1'b0;
            cnt_next = '0;
        end else if ((state_reg == LOAD) || (state_reg == SEND)) begin
            cnt_next = cnt_reg + 1'b1;
            if ((state_reg == LOAD) && !empty_s) ld_next = 1'b0;
        end
    end

    assign gnt             = gnt_reg;
    assign uart_ld_tx_data = ld_reg;
    assign uart_tx_data    = data_reg;
    assign uart_tx_enable  = en_reg;
    assign err_timeout     = err_reg;
    assign busy            = (state_reg != IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench: a 4-requester and a 3-requester arbiter, each
// driving a simple UART model; grants are checked against a queue.
module tb_uart_tx_arbiter;

    localparam int TO = 300;

    typedef struct {
        int         idx;
        logic [7:0] b;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic [3:0]  req0 = '0, lock0 = '0, gnt0;
    logic [31:0] data0 = '0;
    logic        ld0, en0, busy0, err0;
    logic [7:0]  txd0;

    logic [2:0]  req3 = '0, lock3 = '0, gnt3;
    logic [23:0] data3 = '0;
    logic        ld3, en3, busy3, err3;
    logic [7:0]  txd3;

    logic [1:0]  empty;
    int          mcnt [2];
    logic [7:0]  took [2];
    int          hold_len = 8;
    bit          never_take = 1'b0;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          gnt_total0 = 0, gnt_total3 = 0;
    int          err_count = 0, gnt_cyc = 0, err_cyc = 0;
    logic [3:0]  gprev0 = '0;
    logic [2:0]  gprev3 = '0;
    exp_t        q0[$], q3[$];
    exp_t        e0, e3;

    uart_tx_arbiter #(.NREQ(4), .TIMEOUT(TO), .PTR_W(2)) dut (
        .clk             (clk),
        .reset           (rst_n),
        .req             (req0),
        .req_data        (data0),
        .lock            (lock0),
        .gnt             (gnt0),
        .uart_ld_tx_data (ld0),
        .uart_tx_data    (txd0),
        .uart_tx_enable  (en0),
        .uart_tx_empty   (empty[0]),
        .busy            (busy0),
        .err_timeout     (err0)
    );

    uart_tx_arbiter #(.NREQ(3), .TIMEOUT(TO), .PTR_W(2)) dut3 (
        .clk             (clk),
        .reset           (rst_n),
        .req             (req3),
        .req_data        (data3),
        .lock            (lock3),
        .gnt             (gnt3),
        .uart_ld_tx_data (ld3),
        .uart_tx_data    (txd3),
        .uart_tx_enable  (en3),
        .uart_tx_empty   (empty[1]),
        .busy            (busy3),
        .err_timeout     (err3)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // UART model: takes a byte when loaded while empty, stays busy hold_len cycles.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            empty   <= 2'b11;
            mcnt[0] <= 0;
            mcnt[1] <= 0;
        end else begin
            for (int u = 0; u < 2; u++) begin
                if (empty[u] && ((u == 0) ? ld0 : ld3) && !never_take) begin
                    empty[u] <= 1'b0;
                    mcnt[u]  <= hold_len;
                    took[u]  <= (u == 0) ? txd0 : txd3;
                end else if (!empty[u]) begin
                    if (mcnt[u] == 0) empty[u] <= 1'b1;
                    else              mcnt[u] <= mcnt[u] - 1;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Grant monitor pops the scoreboard on every grant pulse.
    always @(negedge clk) begin
        if (gnt0 != 0) begin
            check("gnt0_pulse", 32'(gprev0), 0);
            check("gnt0_onehot", $countones(gnt0), 1);
            if (q0.size() == 0) begin
                check("gnt0_unexpected", 32'(gnt0), 0);
            end else begin
                e0 = q0.pop_front();
                check("gnt0_idx", 32'(gnt0), 1 << e0.idx);
                check("gnt0_data", 32'(txd0), 32'(e0.b));
            end
            $display("grant dut4 gnt %b data %02h at cycle %0d", gnt0, txd0, cyc);
            gnt_total0++;
            gnt_cyc = cyc;
        end
        if (gnt3 != 0) begin
            check("gnt3_pulse", 32'(gprev3), 0);
            check("gnt3_onehot", $countones(gnt3), 1);
            if (q3.size() == 0) begin
                check("gnt3_unexpected", 32'(gnt3), 0);
            end else begin
                e3 = q3.pop_front();
                check("gnt3_idx", 32'(gnt3), 1 << e3.idx);
                check("gnt3_data", 32'(txd3), 32'(e3.b));
            end
            $display("grant dut3 gnt %b data %02h at cycle %0d", gnt3, txd3, cyc);
            gnt_total3++;
        end
        if (err0 || err3) begin
            $display("timeout abort at cycle %0d", cyc);
            err_count++;
            err_cyc = cyc;
        end
        gprev0 = gnt0;
        gprev3 = gnt3;
    end

    task automatic push0(input int idx, input logic [7:0] b);
        exp_t e;
        e.idx = idx;
        e.b   = b;
        q0.push_back(e);
    endtask

    task automatic push3(input int idx, input logic [7:0] b);
        exp_t e;
        e.idx = idx;
        e.b   = b;
        q3.push_back(e);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        req0 = '0; lock0 = '0; req3 = '0; lock3 = '0;
        never_take = 1'b0;
        repeat (3) @(negedge clk);
        gnt_total0 = 0;
        gnt_total3 = 0;
        err_count  = 0;
        rst_n = 1'b1;
        @(negedge clk);
        #1;
    endtask

    task automatic wait_grants(input int unit, input int n);
        for (int i = 0; i < 2000; i++) begin
            if (((unit == 0) ? gnt_total0 : gnt_total3) >= n) break;
            @(negedge clk);
            #1;
        end
        check("grant_count", (unit == 0) ? gnt_total0 : gnt_total3, n);
    endtask

    task automatic wait_idle(input int unit);
        for (int i = 0; i < 2000; i++) begin
            if (((unit == 0) ? busy0 : busy3) == 1'b0) break;
            @(negedge clk);
            #1;
        end
        check("idle", 32'((unit == 0) ? busy0 : busy3), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_gnt", 32'(gnt0), 0);
        check("rst_ld", 32'(ld0), 0);
        check("rst_txd", 32'(txd0), 0);
        check("rst_en", 32'(en0), 0);
        check("rst_busy", 32'(busy0), 0);
        check("rst_err", 32'(err0), 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("en_before_edge", 32'(en0), 0);
        @(negedge clk);
        #1;
        check("en_after_edge", 32'(en0), 1);

        // 1: single requester, slow UART
        apply_reset();
        hold_len = 100;
        data0 = 32'h0000_0041;
        push0(0, 8'h41);
        req0 = 4'b0001;
        @(negedge clk);
        #1;
        check("t1_gnt", 32'(gnt0), 1);
        check("t1_ld", 32'(ld0), 1);
        check("t1_txd", 32'(txd0), 32'h41);
        req0 = '0;
        for (int i = 0; i < 10; i++) begin
            if (!empty[0]) break;
            @(negedge clk);
            #1;
        end
        check("t1_uart_took", 32'(empty[0]), 0);
        check("t1_ld_held", 32'(ld0), 1);
        check("t1_took_byte", 32'(took[0]), 32'h41);
        repeat (4) @(negedge clk);
        #1;
        check("t1_ld_dropped", 32'(ld0), 0);
        check("t1_busy_send", 32'(busy0), 1);
        wait_idle(0);
        check("t1_no_err", err_count, 0);
        check("t1_queue", q0.size(), 0);

        // 2: fairness with all requesting
        apply_reset();
        hold_len = 8;
        data0 = 32'h4030_2010;
        push0(0, 8'h10); push0(1, 8'h20); push0(2, 8'h30);
        push0(3, 8'h40); push0(0, 8'h10); push0(1, 8'h20);
        req0 = 4'b1111;
        wait_grants(0, 6);
        req0 = '0;
        wait_idle(0);
        check("t2_queue", q0.size(), 0);

        // 3: lock keeps requester 0 until released
        apply_reset();
        data0 = 32'h0000_BBAA;
        push0(0, 8'hAA); push0(0, 8'hAA); push0(0, 8'hAA); push0(1, 8'hBB);
        lock0 = 4'b0001;
        req0  = 4'b0011;
        wait_grants(0, 3);
        lock0 = '0;
        wait_grants(0, 4);
        req0 = '0;
        wait_idle(0);
        check("t3_queue", q0.size(), 0);

        // 4: UART never takes the byte
        apply_reset();
        data0 = 32'h00C2_C100;
        never_take = 1'b1;
        push0(1, 8'hC1); push0(2, 8'hC2);
        req0 = 4'b0110;
        wait_grants(0, 1);
        req0 = 4'b0100;
        for (int i = 0; i < TO + 50; i++) begin
            if (err_count > 0) break;
            @(negedge clk);
            #1;
        end
        check("t4_err_seen", err_count, 1);
        check("t4_err_time", err_cyc - gnt_cyc, TO);
        check("t4_ld", 32'(ld0), 0);
        check("t4_busy", 32'(busy0), 0);
        never_take = 1'b0;
        @(negedge clk);
        #1;
        check("t4_err_pulse", 32'(err0), 0);
        wait_grants(0, 2);
        req0 = '0;
        wait_idle(0);
        check("t4_queue", q0.size(), 0);

        // 5: reset while sending
        apply_reset();
        hold_len = 100;
        data0 = 32'h00D2_D100;
        push0(2, 8'hD2);
        req0 = 4'b0100;
        wait_grants(0, 1);
        req0 = '0;
        repeat (10) @(negedge clk);
        #1;
        check("t5_busy_before", 32'(busy0), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_gnt", 32'(gnt0), 0);
        check("t5_ld", 32'(ld0), 0);
        check("t5_txd", 32'(txd0), 0);
        check("t5_busy", 32'(busy0), 0);
        check("t5_err", 32'(err0), 0);
        check("t5_en", 32'(en0), 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("t5_en_low", 32'(en0), 0);
        hold_len = 8;
        push0(1, 8'hD1);
        req0 = 4'b1010;
        @(negedge clk);
        #1;
        check("t5_en_high", 32'(en0), 1);
        wait_grants(0, 2);
        req0 = '0;
        wait_idle(0);
        check("t5_queue", q0.size(), 0);

        // 6: three requesters, non-power-of-two wrap
        apply_reset();
        data3 = 24'hE2_E1_E0;
        push3(0, 8'hE0); push3(1, 8'hE1); push3(2, 8'hE2); push3(0, 8'hE0);
        req3 = 3'b111;
        wait_grants(3, 4);
        req3 = '0;
        wait_idle(3);
        check("t6_queue", q3.size(), 0);
        check("t6_dut4_quiet", gnt_total0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
